// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: steps quadA/quadB one Gray edge at a time toward a commanded target.
// Optional index output quadZ with a CPR revolution counter when QUAD_INDEX_EN is defined.
module quad_encoder_gen #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned CPR      = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_target,
    input  logic [PERIOD_W-1:0] step_period,
    output logic                quadA,
    output logic                quadB,
    output logic [WIDTH-1:0]    position,
    output logic                busy,
    output logic                done
`ifdef QUAD_INDEX_EN
    ,
    output logic                quadZ
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;

    logic [WIDTH-1:0]    target_q;
    logic [WIDTH-1:0]    target_nxt;
    logic [WIDTH-1:0]    pos_nxt;
    logic [WIDTH-1:0]    acc_diff;
    logic [WIDTH-1:0]    goal_c;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] period_nxt;
    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] timer_nxt;
    logic [PERIOD_W-1:0] period_eff_c;
    logic                dir_q;
    logic                dir_nxt;
    logic                step_dir_c;
    logic                step_c;
    logic                arrive_c;
    logic                accept_c;
    logic                acc_move_c;
    logic                done_nxt;
    logic                busy_nxt;

    if (CPR < 1) begin : g_cpr_check
        $error("quad_encoder_gen: CPR must be >= 1");
    end

    assign cmd_ready    = ~rst & (state == ST_IDLE);
    assign accept_c     = cmd_valid & cmd_ready;
    assign period_eff_c = (step_period == '0) ? PERIOD_W'(1) : step_period;
    assign acc_diff     = cmd_target - position;
    assign acc_move_c   = (acc_diff != '0);

    // Step decision: an accepting cycle with period 1 already emits its first edge.
    always_comb begin
        step_c     = 1'b0;
        step_dir_c = dir_q;
        goal_c     = target_q;
        if (state == ST_RUN) begin
            step_c = (timer_q == PERIOD_W'(1));
        end else begin
            step_dir_c = acc_diff[WIDTH-1];
            goal_c     = cmd_target;
            step_c     = accept_c & acc_move_c & (period_eff_c == PERIOD_W'(1));
        end
        pos_nxt = position;
        if (step_c) begin
            pos_nxt = step_dir_c ? (position - WIDTH'(1)) : (position + WIDTH'(1));
        end
        arrive_c = step_c & (pos_nxt == goal_c);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_c && acc_move_c && !arrive_c) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (arrive_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        target_nxt = target_q;
        period_nxt = period_q;
        timer_nxt  = timer_q;
        dir_nxt    = dir_q;
        done_nxt   = 1'b0;
        busy_nxt   = (state_nxt == ST_RUN);
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    target_nxt = cmd_target;
                    period_nxt = period_eff_c;
                    dir_nxt    = acc_diff[WIDTH-1];
                    timer_nxt  = step_c ? period_eff_c : (period_eff_c - PERIOD_W'(1));
                    done_nxt   = ~acc_move_c | arrive_c;
                end
            end
            ST_RUN: begin
                timer_nxt = step_c ? period_q : (timer_q - PERIOD_W'(1));
                done_nxt  = arrive_c;
            end
            default: begin
                done_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs; phase is derived from the count so they can never disagree
    always_ff @(posedge clk) begin
        if (rst) begin
            position <= '0;
            quadA    <= 1'b0;
            quadB    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            target_q <= '0;
            period_q <= PERIOD_W'(1);
            timer_q  <= PERIOD_W'(1);
            dir_q    <= 1'b0;
        end else begin
            position <= pos_nxt;
            quadA    <= pos_nxt[0] ^ pos_nxt[1];
            quadB    <= pos_nxt[1];
            busy     <= busy_nxt;
            done     <= done_nxt;
            target_q <= target_nxt;
            period_q <= period_nxt;
            timer_q  <= timer_nxt;
            dir_q    <= dir_nxt;
        end
    end

`ifdef QUAD_INDEX_EN
    localparam int unsigned REV_W = (CPR > 1) ? $clog2(CPR) : 1;

    logic [REV_W-1:0] rev_q;
    logic [REV_W-1:0] rev_nxt;

    // Revolution counter follows every emitted edge, wrapping in both directions
    always_comb begin
        rev_nxt = rev_q;
        if (step_c) begin
            if (step_dir_c) begin
                rev_nxt = (rev_q == '0) ? REV_W'(CPR - 1) : (rev_q - REV_W'(1));
            end else begin
                rev_nxt = (rev_q == REV_W'(CPR - 1)) ? '0 : (rev_q + REV_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_q <= '0;
            quadZ <= 1'b0;
        end else begin
            rev_q <= rev_nxt;
            quadZ <= (rev_nxt == '0) && (pos_nxt[1:0] == 2'b00);
        end
    end
`endif

endmodule
